// File: rtl/cpu_stack_ctl.sv
// Operand-stack controller: register cache of the top entries, spilling to and filling from a 1-port RAM.
// Ops apply in one IDLE cycle with registered results; a spill or fill holds stall high until the op fits.
module cpu_stack_ctl #(
    parameter int CACHE_DEPTH = 4,
    parameter int RAM_AW      = 10,
    parameter int DEPTH_W     = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         st__pop_cnt,
    input  logic               st__push_en,
    input  logic [34:0]        st__push_data,
    output logic               stall,
    output logic [34:0]        r0,
    output logic [34:0]        r1,
    output logic               r0_valid,
    output logic               r1_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               err_overflow,
    output logic               err_underflow,
    output logic [RAM_AW-1:0]  ram_addr,
    output logic               ram_we,
    output logic [34:0]        ram_wdata,
    input  logic [34:0]        ram_rddata
);
    localparam int CW  = $clog2(CACHE_DEPTH + 1);
    localparam int CIW = $clog2(CACHE_DEPTH);
    localparam logic [CW-1:0]      CD_C     = CW'(CACHE_DEPTH);
    localparam logic [RAM_AW:0]    RAM_FULL = {1'b1, {RAM_AW{1'b0}}};
    localparam logic [DEPTH_W-1:0] MAX_D    = DEPTH_W'(CACHE_DEPTH) + DEPTH_W'(RAM_FULL);

    typedef enum logic [1:0] {IDLE, SPILL, FILL_RD, FILL_WR} state_t;

    state_t              state, state_nxt;
    logic [34:0]         cache     [CACHE_DEPTH];
    logic [34:0]         cache_nxt [CACHE_DEPTH];
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [RAM_AW:0]     ram_sp, sp_nxt;
    logic [RAM_AW-1:0]   addr_q, addr_nxt;
    logic                err_ovf_q, err_unf_q, set_ovf, set_unf;
    logic [DEPTH_W-1:0]  depth_q, total, n_d;
    logic                r0v_q, r1v_q;
    logic                req, consumed, apply_op, apply_push, room_ok, needs_room;
    logic [CW-1:0]       n_c;

    assign req        = (st__pop_cnt != 2'd0) | st__push_en;
    assign n_c        = CW'(st__pop_cnt);
    assign n_d        = DEPTH_W'(st__pop_cnt);
    assign total      = DEPTH_W'(cnt) + DEPTH_W'(ram_sp);
    // With n <= cnt, a push only lacks room when nothing is popped and the cache is full.
    assign room_ok    = !(st__push_en && ((cnt - n_c) == CD_C));
    assign needs_room = req && (n_c <= cnt) && !room_ok;

    always_comb begin : next_p
        int src;
        src        = 0;
        state_nxt  = state;
        cnt_nxt    = cnt;
        sp_nxt     = ram_sp;
        addr_nxt   = addr_q;
        consumed   = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        apply_op   = 1'b0;
        apply_push = 1'b0;
        for (int i = 0; i < CACHE_DEPTH; i++) cache_nxt[i] = cache[i];

        case (state)
            IDLE: begin
                if (req && (n_d > total)) begin
                    consumed = 1'b1;
                    set_unf  = 1'b1;
                    cnt_nxt  = '0;
                    sp_nxt   = '0;
                end else if (st__push_en && ((total - n_d) == MAX_D)) begin
                    consumed = 1'b1;
                    set_ovf  = 1'b1;
                    apply_op = 1'b1;
                end else if (req && (n_c <= cnt) && room_ok) begin
                    consumed   = 1'b1;
                    apply_op   = 1'b1;
                    apply_push = st__push_en;
                end else if ((ram_sp < RAM_FULL) && ((cnt == CD_C) || needs_room)) begin
                    state_nxt = SPILL;
                    addr_nxt  = ram_sp[RAM_AW-1:0];
                end else if ((ram_sp != '0) && ((cnt < CW'(2)) || (req && (n_c > cnt)))) begin
                    state_nxt = FILL_RD;
                    addr_nxt  = RAM_AW'(ram_sp - 1'b1);
                end
            end
            SPILL: begin
                cnt_nxt   = cnt - 1'b1;
                sp_nxt    = ram_sp + 1'b1;
                state_nxt = IDLE;
            end
            FILL_RD: state_nxt = FILL_WR;
            FILL_WR: begin
                cache_nxt[CIW'(cnt)] = ram_rddata;
                cnt_nxt   = cnt + 1'b1;
                sp_nxt    = ram_sp - 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Pop n then optionally push: entry i comes from old index i+n (or i+n-1 below a new top).
        if (apply_op) begin
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                src = i + int'(st__pop_cnt) - int'(apply_push);
                if (apply_push && (i == 0)) cache_nxt[i] = st__push_data;
                else if (src < CACHE_DEPTH) cache_nxt[i] = cache[CIW'(src)];
            end
            cnt_nxt = cnt - n_c + CW'(apply_push);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_sp    <= '0;
            addr_q    <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            depth_q   <= '0;
            r0v_q     <= 1'b0;
            r1v_q     <= 1'b0;
            for (int i = 0; i < CACHE_DEPTH; i++) cache[i] <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            ram_sp    <= sp_nxt;
            addr_q    <= addr_nxt;
            err_ovf_q <= err_ovf_q | set_ovf;
            err_unf_q <= err_unf_q | set_unf;
            depth_q   <= DEPTH_W'(cnt_nxt) + DEPTH_W'(sp_nxt);
            r0v_q     <= (cnt_nxt != '0);
            r1v_q     <= (cnt_nxt >= CW'(2));
            for (int i = 0; i < CACHE_DEPTH; i++) cache[i] <= cache_nxt[i];
        end
    end

    assign stall         = req & ~consumed & ~rst;
    assign r0            = cache[0];
    assign r1            = cache[1];
    assign r0_valid      = r0v_q;
    assign r1_valid      = r1v_q;
    assign depth         = depth_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign ram_addr      = addr_q;
    assign ram_we        = (state == SPILL);
    assign ram_wdata     = cache[CIW'(cnt - 1'b1)];
endmodule

// File: tb/tb_cpu_stack_ctl.sv
// Bench for cpu_stack_ctl: directed scenarios plus random ops, scored against a queue-based stack model.
module tb_cpu_stack_ctl;
    localparam int CD   = 4;
    localparam int AW   = 2;
    localparam int DW   = 12;
    localparam int MAXD = CD + (1 << AW);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pop_cnt = '0;
    logic          push_en = 1'b0;
    logic [34:0]   push_data = '0;
    logic          stall, r0_valid, r1_valid, err_overflow, err_underflow, ram_we;
    logic [34:0]   r0, r1, ram_wdata, rd_q;
    logic [DW-1:0] depth;
    logic [AW-1:0] ram_addr;

    cpu_stack_ctl #(.CACHE_DEPTH(CD), .RAM_AW(AW), .DEPTH_W(DW)) dut (
        .clk(clk), .rst(rst),
        .st__pop_cnt(pop_cnt), .st__push_en(push_en), .st__push_data(push_data),
        .stall(stall), .r0(r0), .r1(r1), .r0_valid(r0_valid), .r1_valid(r1_valid),
        .depth(depth), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rddata(rd_q)
    );

    always #5 clk = ~clk;

    // Backing RAM: one-cycle read latency.
    logic [34:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_q <= mem[ram_addr];
    end

    typedef struct {
        int          depth;
        logic [34:0] top;
        logic [34:0] second;
        logic        eo;
        logic        eu;
        logic        pushed;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [34:0] model[$];
    logic        m_eo = 1'b0, m_eu = 1'b0;
    int          n_chk = 0, n_fail = 0, we_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; pop_cnt = '0; push_en = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        model.delete();
        m_eo = 1'b0;
        m_eu = 1'b0;
    endtask

    // Holds the op until the DUT takes it, then records the expected stack view.
    task automatic do_op(input logic [1:0] n, input logic p, input logic [34:0] d, output int stalls);
        exp_t e;
        int   sz, nn;
        stalls = 0;
        pop_cnt = n; push_en = p; push_data = d;
        @(negedge clk);
        while (stall) begin
            stalls++;
            if (stalls > 16) begin
                n_chk++; n_fail++;
                $display("FAIL op_accept_timeout: still stalled after %0d cycles at %0t", stalls, $time);
                summary();
            end
            @(negedge clk);
        end
        sz = model.size();
        nn = int'(n);
        e.pushed = 1'b0;
        if (nn > sz) begin
            model.delete();
            m_eu = 1'b1;
        end else if (p && (sz - nn == MAXD)) begin
            repeat (nn) void'(model.pop_front());
            m_eo = 1'b1;
        end else begin
            repeat (nn) void'(model.pop_front());
            if (p) begin
                model.push_front(d);
                e.pushed = 1'b1;
            end
        end
        e.depth  = model.size();
        e.top    = (model.size() >= 1) ? model[0] : '0;
        e.second = (model.size() >= 2) ? model[1] : '0;
        e.eo     = m_eo;
        e.eu     = m_eu;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_cnt = '0; push_en = 1'b0;
    endtask

    task automatic clear_cur();
        cur.depth = 0; cur.top = '0; cur.second = '0;
        cur.eo = 1'b0; cur.eu = 1'b0; cur.pushed = 1'b0;
    endtask

    // Monitor: consumes one expectation per accepted op and checks the visible stack every cycle.
    initial begin
        logic acc_prev;
        acc_prev = 1'b0;
        clear_cur();
        forever begin
            @(negedge clk);
            if (ram_we === 1'b1) we_cnt++;
            if (rst) begin
                exp_q.delete();
                acc_prev = 1'b0;
                clear_cur();
            end else begin
                if (acc_prev) begin
                    chk("expect_queued", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        if (cur.pushed) chk("push_r0_valid", 64'(r0_valid), 64'd1);
                    end
                end
                chk("depth", 64'(depth), 64'(cur.depth));
                chk("err_overflow", 64'(err_overflow), 64'(cur.eo));
                chk("err_underflow", 64'(err_underflow), 64'(cur.eu));
                if (cur.depth < 1) chk("r0_valid_empty", 64'(r0_valid), 64'd0);
                else if (r0_valid) chk("r0", 64'(r0), 64'(cur.top));
                if (cur.depth < 2) chk("r1_valid_short", 64'(r1_valid), 64'd0);
                else if (r1_valid) chk("r1", 64'(r1), 64'(cur.second));
                acc_prev = ((pop_cnt != 2'd0) || push_en) && !stall;
            end
        end
    end

    initial begin
        #1_000_000;
        n_chk++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
    end

    initial begin
        int s;
        // Reset state.
        do_reset(2);
        @(negedge clk);
        chk("rst_depth", 64'(depth), 64'd0);
        chk("rst_r0_valid", 64'(r0_valid), 64'd0);
        chk("rst_r1_valid", 64'(r1_valid), 64'd0);
        chk("rst_r0", 64'(r0), 64'd0);
        chk("rst_r1", 64'(r1), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", 64'(ram_addr), 64'd0);
        chk("rst_err_ovf", 64'(err_overflow), 64'd0);
        chk("rst_err_unf", 64'(err_underflow), 64'd0);
        @(posedge clk); #1;

        // Three pushes fit in the cache without touching RAM.
        we_cnt = 0;
        do_op(2'd0, 1'b1, 35'h1_0000_0011, s); chk("s1_push1_stall", 64'(s), 64'd0);
        do_op(2'd0, 1'b1, 35'h1_0000_0022, s); chk("s1_push2_stall", 64'(s), 64'd0);
        do_op(2'd0, 1'b1, 35'h1_0000_0033, s); chk("s1_push3_stall", 64'(s), 64'd0);
        @(negedge clk);
        chk("s1_r0", 64'(r0), 64'h1_0000_0033);
        chk("s1_r1", 64'(r1), 64'h1_0000_0022);
        chk("s1_depth", 64'(depth), 64'd3);
        chk("s1_valids", 64'({r0_valid, r1_valid}), 64'd3);
        chk("s1_no_ram_we", 64'(we_cnt), 64'd0);
        @(posedge clk); #1;

        // Fifth push stalls for the launching cycle plus SPILL; then pop 3 and let a fill restore r1.
        do_reset(2);
        for (int i = 1; i <= 4; i++) begin
            do_op(2'd0, 1'b1, 35'(i), s);
            chk("s2_push_stall", 64'(s), 64'd0);
        end
        do_op(2'd0, 1'b1, 35'd5, s);
        chk("s2_push5_stall", 64'(s), 64'd2);
        chk("s2_spill_data", 64'(mem[0]), 64'd1);
        do_op(2'd3, 1'b0, 35'd0, s);
        chk("s2_pop3_stall", 64'(s), 64'd0);
        idle(4);
        @(negedge clk);
        chk("s2_r0", 64'(r0), 64'd2);
        chk("s2_r1", 64'(r1), 64'd1);
        chk("s2_r1_valid", 64'(r1_valid), 64'd1);
        chk("s2_depth", 64'(depth), 64'd2);
        @(posedge clk); #1;

        // cnt=2 with two entries in RAM: pop 3 waits for one fill (3 stall cycles).
        do_reset(2);
        for (int i = 1; i <= 4; i++) do_op(2'd0, 1'b1, 35'(i), s);
        idle(3);
        do_op(2'd0, 1'b1, 35'd5, s);
        idle(3);
        do_op(2'd1, 1'b0, 35'd0, s);
        idle(2);
        do_op(2'd3, 1'b0, 35'd0, s);
        chk("s3_pop3_stall", 64'(s), 64'd3);
        idle(5);
        @(negedge clk);
        chk("s3_depth", 64'(depth), 64'd1);
        chk("s3_r0", 64'(r0), 64'd1);
        @(posedge clk); #1;

        // Underflow clears the stack without stalling; the error is sticky.
        do_op(2'd2, 1'b0, 35'd0, s);
        chk("s4_unf_stall", 64'(s), 64'd0);
        @(negedge clk);
        chk("s4_err_unf", 64'(err_underflow), 64'd1);
        chk("s4_depth", 64'(depth), 64'd0);
        chk("s4_r0_valid", 64'(r0_valid), 64'd0);
        @(posedge clk); #1;
        do_op(2'd0, 1'b1, 35'h7, s);
        @(negedge clk);
        chk("s4_r0_after", 64'(r0), 64'h7);
        chk("s4_err_sticky", 64'(err_underflow), 64'd1);
        @(posedge clk); #1;

        // Overflow with an 8-entry stack, then reset in the middle of a fill.
        do_reset(2);
        for (int i = 0; i < 8; i++) do_op(2'd0, 1'b1, 35'(32'h100 + i), s);
        do_op(2'd0, 1'b1, 35'h1ff, s);
        chk("s5_ovf_stall", 64'(s), 64'd0);
        @(negedge clk);
        chk("s5_err_ovf", 64'(err_overflow), 64'd1);
        chk("s5_depth", 64'(depth), 64'd8);
        chk("s5_r0", 64'(r0), 64'h107);
        @(posedge clk); #1;
        do_op(2'd3, 1'b0, 35'd0, s);
        @(posedge clk); #1;
        do_reset(1);
        @(negedge clk);
        chk("s5_rst_depth", 64'(depth), 64'd0);
        chk("s5_rst_ram_we", 64'(ram_we), 64'd0);
        chk("s5_rst_errs", 64'({err_overflow, err_underflow}), 64'd0);
        chk("s5_rst_r0_valid", 64'(r0_valid), 64'd0);
        @(posedge clk); #1;
        idle(3);
        @(negedge clk);
        chk("s5_no_stale_fill", 64'({r0_valid, depth}), 64'd0);
        @(posedge clk); #1;
        do_op(2'd0, 1'b1, 35'h55, s);
        chk("s5_post_rst_push_stall", 64'(s), 64'd0);

        // Random ops with idle gaps so spills and fills interleave.
        for (int k = 0; k < 400; k++) begin
            logic [1:0]  n;
            logic        p;
            logic [2:0]  t;
            logic [34:0] d;
            int          r;
            if (k % 100 == 0) do_reset(2);
            idle(int'($urandom_range(0, 2)));
            r = int'($urandom_range(0, 99));
            n = (r < 55) ? 2'd0 : (r < 80) ? 2'd1 : (r < 92) ? 2'd2 : 2'd3;
            p = ($urandom_range(0, 99) < ((model.size() < 6) ? 75 : 45));
            if (n == 2'd0) p = 1'b1;
            t = 3'($urandom_range(0, 7));
            d = {t, 32'($urandom())};
            do_op(n, p, d, s);
        end
        idle(8);
        summary();
    end
endmodule
